mem_uart_tx: RTL
================

Name: mem_uart_tx

Overview:
- Memory-to-PC transmit engine: the sending end of the PC serial link whose receive path loads data memory.
- On a transmit request, it reads BYTE_COUNT consecutive bytes from data memory, starting at START_ADDR.
- Each byte is serialized as a UART 8N1 frame on data_to_pc.
- It signals completion to main control with a one-cycle end_transmitting pulse.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (must be >= 2).
- ADDR_W, 16, data memory address width.
- START_ADDR, 0, first data memory address transmitted.
- BYTE_COUNT, 256, number of bytes per transmission (1 to 2^ADDR_W).

Ports:
- clock  input  1  system clock (the slow clock domain).
- reset_n  input  1  asynchronous active-low reset.
- begin_transmit  input  1  debounced transmit request, level; acted on at its rising edge.
- mem_data  input  8  data memory read data; valid one cycle after mem_addr is registered.
- mem_addr  output  ADDR_W  data memory read address.
- mem_rd_en  output  1  high during the memory fetch cycle.
- data_to_pc  output  1  UART serial line; idles high.
- busy  output  1  high from transmission start until end_transmitting.
- end_transmitting  output  1  one-cycle pulse when the last stop bit completes.

Behaviour:
- Reset (asynchronous, while reset_n=0):
  - data_to_pc=1, busy=0, end_transmitting=0, mem_rd_en=0, mem_addr=START_ADDR.
  - state=IDLE; bit counter, baud counter and byte counter = 0; begin_transmit edge register cleared.
- Rising-edge detect:
  - begin_d is begin_transmit delayed by 1 cycle; a request is begin_transmit=1 and begin_d=0.
  - A level held high after completion never retriggers.
  - Requests while busy=1 are ignored and not queued.
- IDLE:
  - data_to_pc=1.
  - On a request: mem_addr<=START_ADDR, byte counter<=0, busy<=1, go to FETCH.
- FETCH (1 cycle): mem_rd_en=1, address stable; go to LOAD.
- LOAD (1 cycle):
  - Shift register <= mem_data; go to START.
  - data_to_pc stays high during FETCH and LOAD, giving a 2-cycle idle gap before each frame.
- START: data_to_pc=0 for exactly CLKS_PER_BIT cycles; go to DATA.
- DATA:
  - 8 bits, LSB first, each held exactly CLKS_PER_BIT cycles.
  - Shift right after each bit; bit counter 0..7.
- STOP: data_to_pc=1 for CLKS_PER_BIT cycles. Then:
  - If byte counter = BYTE_COUNT-1: go to DONE.
  - Else: byte counter+1, mem_addr+1 (wraps modulo 2^ADDR_W), go to FETCH.
- DONE (1 cycle): end_transmitting=1, busy<=0, go to IDLE.
- Timing:
  - Frame = 10*CLKS_PER_BIT cycles on the line.
  - Total busy duration = BYTE_COUNT*(10*CLKS_PER_BIT+2)+1 cycles.
  - data_to_pc is driven from a register (glitch-free).
- Baud counter: counts 0..CLKS_PER_BIT-1 and resets at each bit boundary.
- Boundary conditions:
  - BYTE_COUNT=1: single frame, then DONE.
  - START_ADDR+BYTE_COUNT beyond the top of memory: address wraps to 0.
  - begin_transmit falling mid-transmission has no effect.
  - Reset mid-frame: line goes high immediately, no end_transmitting pulse, a fresh request is required.

Test Plan:
- Reset:
  - Stimulus: assert reset_n=0 mid-operation, then release.
  - Required: data_to_pc=1, busy=0, end_transmitting=0, mem_addr=START_ADDR; no activity until a begin_transmit rising edge.
- Single byte:
  - Stimulus: CLKS_PER_BIT=4, BYTE_COUNT=1, mem[0]=0xA5, pulse begin_transmit.
  - Required: mem_rd_en for 1 cycle at addr 0; line sequence 0,1,0,1,0,0,1,0,1,1, each level 4 cycles; end_transmitting pulses once, 1 cycle after the stop bit; busy high for 43 cycles.
- Multi-byte:
  - Stimulus: BYTE_COUNT=3, mem[0..2]=0x00,0xFF,0x3C.
  - Required: addresses 0,1,2 fetched in order; 3 correctly decoded frames with a 2-cycle high gap between them; exactly one end_transmitting pulse.
- Held request:
  - Stimulus: begin_transmit held high through completion and 100 cycles beyond.
  - Required: no second transmission; a new low-to-high edge starts a new one.
- Request during busy:
  - Stimulus: a second begin_transmit edge mid-frame.
  - Required: ignored; byte sequence and done timing unchanged.
- Wrap:
  - Stimulus: ADDR_W=4, START_ADDR=14, BYTE_COUNT=4.
  - Required: mem_addr sequence 14,15,0,1.

Source files
------------

// File: rtl/mem_uart_tx.sv
// Memory-to-PC transmit engine: fetches BYTE_COUNT bytes from data memory
// and sends each one as a UART 8N1 frame, then pulses end_transmitting.
module mem_uart_tx #(
  parameter int                CLKS_PER_BIT = 434,
  parameter int                ADDR_W       = 16,
  parameter logic [ADDR_W-1:0] START_ADDR   = '0,
  parameter int                BYTE_COUNT   = 256
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              begin_transmit,
  input  logic [7:0]        mem_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  output logic              data_to_pc,
  output logic              busy,
  output logic              end_transmitting
);

  localparam int                BAUD_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W-1:0] LAST_BYTE = ADDR_W'(BYTE_COUNT - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    STOP,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [2:0]          bit_q, bit_d;
  logic [ADDR_W-1:0]   byte_q, byte_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          shift_q, shift_d;
  logic                busy_q, busy_d;
  logic                line_q, line_d;
  logic                end_q, end_d;
  logic                begin_d;
  logic                request;
  logic                baud_end;

  // Only a low-to-high transition starts a transmission; a held level never retriggers.
  assign request  = begin_transmit & ~begin_d;
  assign baud_end = (baud_q == BAUD_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      addr_q  <= START_ADDR;
      shift_q <= '0;
      busy_q  <= 1'b0;
      line_q  <= 1'b1;
      end_q   <= 1'b0;
      begin_d <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      addr_q  <= addr_d;
      shift_q <= shift_d;
      busy_q  <= busy_d;
      line_q  <= line_d;
      end_q   <= end_d;
      begin_d <= begin_transmit;
    end
  end

  // The line value is decided one cycle ahead so data_to_pc comes straight from a flop.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    addr_d  = addr_q;
    shift_d = shift_q;
    busy_d  = busy_q;
    line_d  = 1'b1;
    end_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (request) begin
          addr_d  = START_ADDR;
          byte_d  = '0;
          busy_d  = 1'b1;
          state_d = FETCH;
        end
      end

      FETCH: begin
        state_d = LOAD;
      end

      LOAD: begin
        shift_d = mem_data;
        baud_d  = '0;
        line_d  = 1'b0;
        state_d = START;
      end

      START: begin
        line_d = 1'b0;
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          line_d  = shift_q[0];
          state_d = DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      DATA: begin
        line_d = shift_q[0];
        if (baud_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            line_d  = 1'b1;
            state_d = STOP;
          end else begin
            bit_d  = bit_q + 3'd1;
            line_d = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (byte_q == LAST_BYTE) begin
            end_d   = 1'b1;
            state_d = DONE;
          end else begin
            byte_d  = byte_q + ADDR_W'(1);
            addr_d  = addr_q + ADDR_W'(1);
            state_d = FETCH;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mem_addr         = addr_q;
  assign mem_rd_en        = (state_q == FETCH);
  assign data_to_pc       = line_q;
  assign busy             = busy_q;
  assign end_transmitting = end_q;

endmodule
